// File: rtl/polar_encoder_if.sv
// polar_encoder_if: input and output beat streams of the polar encoder.
// The slave modport is the encoder side, master is the source/sink side.
interface polar_encoder_if #(
    parameter int P = 16
);
    logic         in_valid;
    logic         in_ready;
    logic [P-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [P-1:0] out_data;
    logic         out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/polar_encoder.sv
// polar_encoder: frame-buffered polar encoder x = u*F^(xn) over GF(2).
// Define POLAR_ENC_BITREV_EN to emit the codeword in bit-reversed order.
module polar_encoder #(
    parameter int N = 1024,
    parameter int P = 16
) (
    input logic            clk,
    input logic            rst_n,
    polar_encoder_if.slave bus
);
    localparam int LOGN  = $clog2(N);
    localparam int LOGP  = $clog2(P);
    localparam int BEATS = N / P;
    localparam int CW    = $clog2(BEATS);
    localparam logic [CW-1:0]   CNT_LAST = CW'(BEATS - 1);
    localparam logic [LOGN-1:0] STG_LAST = LOGN'(LOGN - 1);

    typedef enum logic [1:0] {
        LOAD,
        ENC,
        OUT
    } state_t;

    state_t          state;
    logic [N-1:0]    frame;
    logic [CW-1:0]   cnt;
    logic [LOGN-1:0] stg;
    logic            in_ready_q;
    logic            out_valid_q;
    logic            out_last_q;
    logic [N-1:0]    stage_next;
    logic [N-1:0]    out_order;
    logic [LOGN-1:0] word_base;

    assign word_base = {cnt, {LOGP{1'b0}}};

    // One butterfly stage in place: pair j with j+2^s where bit s of j is 0
    always_comb begin
        stage_next = frame;
        for (int s = 0; s < LOGN; s++) begin
            if (stg == LOGN'(s)) begin
                for (int j = 0; j < N; j++) begin
                    if (((j >> s) & 1) == 0)
                        stage_next[j] = frame[j] ^ frame[j | (1 << s)];
                end
            end
        end
    end

`ifdef POLAR_ENC_BITREV_EN
    function automatic logic [LOGN-1:0] rev(input logic [LOGN-1:0] v);
        logic [LOGN-1:0] r;
        for (int k = 0; k < LOGN; k++)
            r[k] = v[LOGN-1-k];
        return r;
    endfunction

    always_comb begin
        out_order = '0;
        for (int i = 0; i < N; i++)
            out_order[i] = frame[rev(LOGN'(i))];
    end
`else
    assign out_order = frame;
`endif

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_data  = out_valid_q ? out_order[word_base +: P] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= LOAD;
            frame       <= '0;
            cnt         <= '0;
            stg         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            unique case (state)
                LOAD: begin
                    if (bus.in_valid) begin
                        frame[word_base +: P] <= bus.in_data;
                        if (cnt == CNT_LAST) begin
                            cnt        <= '0;
                            stg        <= '0;
                            in_ready_q <= 1'b0;
                            state      <= ENC;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                ENC: begin
                    frame <= stage_next;
                    if (stg == STG_LAST) begin
                        cnt         <= '0;
                        out_valid_q <= 1'b1;
                        out_last_q  <= (BEATS == 1);
                        state       <= OUT;
                    end else begin
                        stg <= stg + LOGN'(1);
                    end
                end
                OUT: begin
                    if (bus.out_ready) begin
                        if (cnt == CNT_LAST) begin
                            cnt         <= '0;
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            in_ready_q  <= 1'b1;
                            state       <= LOAD;
                        end else begin
                            cnt        <= cnt + CW'(1);
                            out_last_q <= (cnt + CW'(1) == CNT_LAST);
                        end
                    end
                end
                default: begin
                    state       <= LOAD;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    out_last_q  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_polar_encoder.sv
// tb_polar_encoder: directed frame vectors, involution, stall and reset
// sequences for polar_encoder.
module tb_polar_encoder;
    localparam int N     = 1024;
    localparam int P     = 16;
    localparam int BEATS = N / P;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    polar_encoder_if #(.P(P)) bus ();

    polar_encoder #(.N(N), .P(P)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          ubit;
        int          ka;
        logic [15:0] va;
        int          kb;
        logic [15:0] vb;
        logic [15:0] rest;
    } vec_t;

    vec_t tbl [8];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [N-1:0] unrev(input logic [N-1:0] y);
        logic [N-1:0] x;
        int r;
        for (int i = 0; i < N; i++) begin
            r = 0;
            for (int b = 0; b < 10; b++)
                if (((i >> b) & 1) == 1) r = r | (1 << (9 - b));
            x[i] = y[r];
        end
        return x;
    endfunction

    task automatic send_frame(input logic [N-1:0] u, input bit bubbles);
        int k = 0;
        int guard = 0;
        while (k < BEATS && guard < 1000) begin
            bus.in_valid = bubbles ? ($urandom_range(3) != 0) : 1'b1;
            bus.in_data  = u[k*P +: P];
            @(posedge clk);
            if (bus.in_valid && bus.in_ready) k++;
            #1;
            guard++;
        end
        bus.in_valid = 1'b0;
        if (k != BEATS) check("load_timeout", k, BEATS);
    endtask

    task automatic wait_valid(input bit chk);
        int n = 0;
        while (!bus.out_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (chk) check("latency", n, 10);
        else if (!bus.out_valid) check("valid_timeout", 0, 1);
    endtask

    task automatic recv_frame(output logic [N-1:0] x, input int nbeats,
                              input bit stall, input bit junk);
        int k = 0;
        int guard = 0;
        int hold = 0;
        bit did = 0;
        bit pend = 0;
        logic [15:0] held = '0;
        x = '0;
        if (junk) begin
            bus.in_valid = 1'b1;
            bus.in_data  = '1;
        end
        while (k < nbeats && guard < 2000) begin
            if (stall && k == 32 && !did) begin
                hold = 5;
                did  = 1;
            end
            if (hold > 0) begin
                bus.out_ready = 1'b0;
                hold--;
            end else begin
                bus.out_ready = stall ? ($urandom_range(1) == 1) : 1'b1;
            end
            @(posedge clk);
            if (pend) begin
                check("stall_valid", bus.out_valid, 1);
                check("stall_data", bus.out_data, held);
            end
            if (stall) check("drain_in_ready", bus.in_ready, 0);
            pend = 0;
            if (bus.out_valid && bus.out_ready) begin
                x[k*P +: P] = bus.out_data;
                check($sformatf("out_last_b%0d", k), bus.out_last,
                      32'(k == BEATS - 1));
                k++;
            end else if (bus.out_valid) begin
                pend = 1;
                held = bus.out_data;
            end
            #1;
            guard++;
        end
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        if (k != nbeats) check("drain_timeout", k, nbeats);
    endtask

    task automatic run_vec(input vec_t v, input int id, input bit bubbles);
        logic [N-1:0] u;
        logic [N-1:0] x;
        logic [15:0] e;
        u = '0;
        if (v.ubit >= 0) u[v.ubit] = 1'b1;
        send_frame(u, bubbles);
        wait_valid(1);
        recv_frame(x, BEATS, 0, 0);
        check("in_ready_after_last", bus.in_ready, 1);
        for (int k = 0; k < BEATS; k++) begin
            e = (k == v.ka) ? v.va : ((k == v.kb) ? v.vb : v.rest);
            check($sformatf("vec%0d_beat%0d", id, k), x[k*P +: P], e);
        end
    endtask

    task automatic rand_frame(output logic [N-1:0] u);
        for (int w = 0; w < N / 32; w++)
            u[w*32 +: 32] = $urandom;
    endtask

    initial begin
        logic [N-1:0] u;
        logic [N-1:0] x;
        logic [N-1:0] y;
        logic [N-1:0] g;

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

`ifdef POLAR_ENC_BITREV_EN
        tbl[0] = '{-1,   0, 16'h0000, 0,  16'h0000, 16'h0000};
        tbl[1] = '{1023, 0, 16'hFFFF, 0,  16'hFFFF, 16'hFFFF};
        tbl[2] = '{0,    0, 16'h0001, 0,  16'h0001, 16'h0000};
        tbl[3] = '{1,    0, 16'h0001, 32, 16'h0001, 16'h0000};
        tbl[4] = '{16,   0, 16'h0001, 2,  16'h0001, 16'h0000};
        tbl[5] = '{512,  0, 16'h0003, 0,  16'h0003, 16'h0000};
        tbl[6] = '{2,    0, 16'h0001, 16, 16'h0001, 16'h0000};
        tbl[7] = '{768,  0, 16'h000F, 0,  16'h000F, 16'h0000};
`else
        tbl[0] = '{-1,   0, 16'h0000, 0,  16'h0000, 16'h0000};
        tbl[1] = '{1023, 0, 16'hFFFF, 0,  16'hFFFF, 16'hFFFF};
        tbl[2] = '{0,    0, 16'h0001, 0,  16'h0001, 16'h0000};
        tbl[3] = '{1,    0, 16'h0003, 0,  16'h0003, 16'h0000};
        tbl[4] = '{16,   0, 16'h0001, 1,  16'h0001, 16'h0000};
        tbl[5] = '{15,   0, 16'hFFFF, 0,  16'hFFFF, 16'h0000};
        tbl[6] = '{17,   0, 16'h0003, 1,  16'h0003, 16'h0000};
        tbl[7] = '{1008, 0, 16'h0001, 0,  16'h0001, 16'h0001};
`endif

        #12;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_last", bus.out_last, 0);
        check("rst_out_data", bus.out_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", bus.in_ready, 1);

        for (int t = 0; t < 8; t++)
            run_vec(tbl[t], t, (t % 2) == 1);

        for (int i = 0; i < 20; i++) begin
            rand_frame(u);
            send_frame(u, 0);
            wait_valid(0);
            recv_frame(x, BEATS, 0, 0);
`ifdef POLAR_ENC_BITREV_EN
            x = unrev(x);
`endif
            send_frame(x, 0);
            wait_valid(0);
            recv_frame(y, BEATS, 0, 0);
`ifdef POLAR_ENC_BITREV_EN
            y = unrev(y);
`endif
            check($sformatf("involution_%0d", i), 32'(y === u), 1);
        end

        rand_frame(u);
        send_frame(u, 0);
        wait_valid(0);
        recv_frame(g, BEATS, 0, 0);
        send_frame(u, 1);
        wait_valid(1);
        recv_frame(x, BEATS, 1, 1);
        check("stall_in_ready_after", bus.in_ready, 1);
        for (int k = 0; k < BEATS; k++)
            check($sformatf("stall_beat%0d", k), x[k*P +: P], g[k*P +: P]);

        rand_frame(u);
        send_frame(u, 0);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("enc_rst_out_valid", bus.out_valid, 0);
        check("enc_rst_out_last", bus.out_last, 0);
        check("enc_rst_out_data", bus.out_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("enc_rst_in_ready", bus.in_ready, 1);
        run_vec(tbl[1], 101, 0);

        rand_frame(u);
        send_frame(u, 0);
        wait_valid(1);
        recv_frame(x, 30, 0, 0);
        check("pre_rst_out_valid", bus.out_valid, 1);
        rst_n = 1'b0;
        #1;
        check("out_rst_out_valid", bus.out_valid, 0);
        check("out_rst_out_last", bus.out_last, 0);
        check("out_rst_out_data", bus.out_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("out_rst_in_ready", bus.in_ready, 1);
        run_vec(tbl[2], 102, 0);
        run_vec(tbl[3], 103, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
